// File: rtl/alu_pkg.sv
// Shared definitions for the ALU UART front end: FSM state encoding and
// the opcode values understood by the attached ALU.
package alu_pkg;

    // Command sequencer states: three byte-capture phases, ALU handshake, TX push
    typedef enum logic [2:0] {
        IDLE_A = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUBU = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_SRA  = 6'b100111;
    localparam logic [5:0] OP_SRL  = 6'b101000;
    localparam logic [5:0] OP_NOR  = 6'b101001;

endpackage

// File: rtl/alu_uart_if_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// expiry once the count reaches TIMEOUT_CYCLES-1. Only built when the top
// is compiled with ALU_UART_IF_TIMEOUT_EN.
module alu_uart_if_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign o_expire = (count == LAST);

    // Idle-cycle counter; holds at the limit until the owner clears it
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable && !o_expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_uart_if.sv
// ALU <-> UART glue: pops operand A, operand B and opcode bytes from the RX
// FIFO, runs one ALU request and pushes the result byte to the TX FIFO.
// Optional build macro ALU_UART_IF_TIMEOUT_EN adds an inter-byte watchdog that
// abandons a partially received command after TIMEOUT_CYCLES idle cycles.
module alu_uart_if
    import alu_pkg::*;
#(
    parameter int unsigned DATA_SIZE      = 8,
    parameter int unsigned OPCODE_SIZE    = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_rx_empty,
    input  logic [DATA_SIZE-1:0]   i_rx_data,
    output logic                   o_rx_rd,
    output logic [DATA_SIZE-1:0]   o_operando_a,
    output logic [DATA_SIZE-1:0]   o_operando_b,
    output logic [OPCODE_SIZE-1:0] o_opcode,
    output logic                   o_start,
    input  logic [DATA_SIZE-1:0]   i_alu_result,
    input  logic                   i_alu_result_ready,
    input  logic                   i_tx_full,
    output logic [DATA_SIZE-1:0]   o_tx_data,
    output logic                   o_tx_wr,
    output logic                   o_busy
);

    // Reject configurations the byte-slicing and watchdog cannot support
    if (OPCODE_SIZE > DATA_SIZE || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("alu_uart_if: OPCODE_SIZE must fit in DATA_SIZE and TIMEOUT_CYCLES must be >= 2");
    end

    state_t               state;
    logic [DATA_SIZE-1:0] result;
    logic                 rx_phase;
    logic                 pop;
    logic                 timeout;

    // The registered pop strobe is still in flight during the cycle after a
    // capture, so the FIFO head is stale then; skipping that cycle also keeps
    // o_rx_rd from ever being high on two consecutive cycles.
    assign rx_phase = (state == IDLE_A) || (state == GET_B) || (state == GET_OP);
    assign pop      = rx_phase && !i_rx_empty && !o_rx_rd;
    assign o_busy   = (state != IDLE_A);

`ifdef ALU_UART_IF_TIMEOUT_EN
    logic waiting_byte;
    logic expire;

    assign waiting_byte = (state == GET_B) || (state == GET_OP);
    assign timeout      = waiting_byte && expire;

    alu_uart_if_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (pop || (state == IDLE_A)),
        .i_enable (waiting_byte),
        .o_expire (expire)
    );
`else
    assign timeout = 1'b0;
`endif

    // Command sequencer with registered strobes, operands and result
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state        <= IDLE_A;
            o_operando_a <= '0;
            o_operando_b <= '0;
            o_opcode     <= '0;
            result       <= '0;
            o_tx_data    <= '0;
            o_start      <= 1'b0;
            o_rx_rd      <= 1'b0;
            o_tx_wr      <= 1'b0;
        end else begin
            // NOTE: strobes default low each cycle so each branch only states when a pulse is wanted.
            o_rx_rd <= 1'b0;
            o_tx_wr <= 1'b0;
            if (timeout) begin
                state        <= IDLE_A;
                o_operando_a <= '0;
                o_operando_b <= '0;
                o_opcode     <= '0;
            end else begin
                case (state)
                    IDLE_A: if (pop) begin
                        o_operando_a <= i_rx_data;
                        o_rx_rd      <= 1'b1;
                        state        <= GET_B;
                    end
                    GET_B: if (pop) begin
                        o_operando_b <= i_rx_data;
                        o_rx_rd      <= 1'b1;
                        state        <= GET_OP;
                    end
                    GET_OP: if (pop) begin
                        o_opcode <= i_rx_data[OPCODE_SIZE-1:0];
                        o_rx_rd  <= 1'b1;
                        state    <= EXEC;
                    end
                    // Raise start once the pop pulse has dropped; accept the result only while start is up
                    EXEC: begin
                        if (!o_start) begin
                            o_start <= 1'b1;
                        end else if (i_alu_result_ready) begin
                            result  <= i_alu_result;
                            o_start <= 1'b0;
                            state   <= SEND;
                        end
                    end
                    SEND: if (!i_tx_full) begin
                        o_tx_data <= result;
                        o_tx_wr   <= 1'b1;
                        state     <= IDLE_A;
                    end
                    default: state <= IDLE_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_uart_if.sv
// Self-checking bench for alu_uart_if: FIFO and ALU environment models, a
// transaction-level scoreboard checked every cycle, and directed vectors.
module tb_alu_uart_if;
    import alu_pkg::*;

`ifdef ALU_UART_IF_TIMEOUT_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 1000000;
`endif

    logic       i_clk;
    logic       i_reset;
    logic       i_rx_empty;
    logic [7:0] i_rx_data;
    logic       o_rx_rd;
    logic [7:0] o_operando_a;
    logic [7:0] o_operando_b;
    logic [5:0] o_opcode;
    logic       o_start;
    logic [7:0] i_alu_result;
    logic       i_alu_result_ready;
    logic       i_tx_full;
    logic [7:0] o_tx_data;
    logic       o_tx_wr;
    logic       o_busy;

    alu_uart_if #(
        .DATA_SIZE(8), .OPCODE_SIZE(6), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_empty(i_rx_empty), .i_rx_data(i_rx_data), .o_rx_rd(o_rx_rd),
        .o_operando_a(o_operando_a), .o_operando_b(o_operando_b),
        .o_opcode(o_opcode), .o_start(o_start),
        .i_alu_result(i_alu_result), .i_alu_result_ready(i_alu_result_ready),
        .i_tx_full(i_tx_full), .o_tx_data(o_tx_data), .o_tx_wr(o_tx_wr),
        .o_busy(o_busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] trip[3];
    logic [7:0] cur_a, cur_b, cur_op;
    logic [5:0] last_start_op;
    int  grp = 0, owed = 0, cyc = 0, t_last = 0, start_cyc = 0, alu_delay = 0;
    bit  prev_rd = 0, full_at_edge = 0, chk_busy = 1, lat_chk = 1, start_seen = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference ALU, written from the opcode meanings (shifts move B by A)
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUBU: return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return $unsigned($signed(b) >>> a);
            OP_SRL:  return b >> a;
            OP_NOR:  return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result       = alu_model(o_operando_a, o_operando_b, o_opcode);
    assign i_alu_result_ready = o_start && (start_cyc > alu_delay);

    function automatic void refresh();
        i_rx_empty = (rx_q.size() == 0);
        i_rx_data  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    endfunction

    always @(posedge i_clk) begin
        cyc++;
        full_at_edge = i_tx_full;
    end

    // Scoreboard: FIFO pops, command grouping, expected results, per-cycle rules
    always @(negedge i_clk) begin
        if (!i_reset) begin
            grp = 0; owed = 0; exp_q.delete(); prev_rd = 0; start_cyc = 0;
        end else begin
            check("strobes_exclusive", $onehot0({o_start, o_rx_rd, o_tx_wr}), 1);
            if (o_rx_rd) begin
                check("rd_when_not_empty", i_rx_empty, 0);
                check("rd_not_back_to_back", prev_rd, 0);
                if (rx_q.size() != 0) begin
                    trip[grp] = rx_q.pop_front();
                    refresh();
                    grp++;
                    if (grp == 3) begin
                        cur_a = trip[0]; cur_b = trip[1]; cur_op = trip[2];
                        exp_q.push_back(alu_model(cur_a, cur_b, cur_op[5:0]));
                        owed++; grp = 0; t_last = cyc;
                    end
                end
            end
            prev_rd = o_rx_rd;
            if (o_start) begin
                start_cyc++;
                start_seen = 1;
                last_start_op = o_opcode;
                check("start_operand_a", o_operando_a, cur_a);
                check("start_operand_b", o_operando_b, cur_b);
                check("start_opcode", o_opcode, cur_op[5:0]);
            end else begin
                start_cyc = 0;
            end
            if (o_tx_wr) begin
                check("wr_only_when_not_full", full_at_edge, 0);
                check("wr_has_pending_result", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("tx_data", o_tx_data, exp_q.pop_front());
                if (lat_chk) check("pop_to_wr_latency", cyc - t_last, 3);
                tx_log.push_back(o_tx_data);
                if (owed > 0) owed--;
            end
            if (chk_busy) check("busy", o_busy, (grp != 0) || (owed != 0));
        end
    end

    task automatic push(input logic [7:0] d);
        @(posedge i_clk); #2;
        rx_q.push_back(d);
        refresh();
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (tx_log.size() < n && k < budget) begin
            @(negedge i_clk); #1;
            k++;
        end
        check("write_arrived_in_time", tx_log.size() >= n, 1);
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] lit);
        int n;
        n = tx_log.size() + 1;
        push(a); push(b); push(op);
        wait_writes(n, 200);
        if (tx_log.size() >= n) check(name, tx_log[n-1], lit);
    endtask

    task automatic check_all_zero();
        check("rst_operando_a", o_operando_a, 0);
        check("rst_operando_b", o_operando_b, 0);
        check("rst_opcode", o_opcode, 0);
        check("rst_tx_data", o_tx_data, 0);
        check("rst_start", o_start, 0);
        check("rst_rx_rd", o_rx_rd, 0);
        check("rst_tx_wr", o_tx_wr, 0);
        check("rst_busy", o_busy, 0);
    endtask

    initial begin
        int n0, k;
        i_reset = 1'b0; i_tx_full = 1'b0;
        refresh();
        repeat (3) @(posedge i_clk);
        #1 check_all_zero();
        @(posedge i_clk); #2 i_reset = 1'b1;

        // Arithmetic vectors with hand-computed results
        run_op("add_05_03", 8'h05, 8'h03, 8'h20, 8'h08);
        run_op("subu_03_05", 8'h03, 8'h05, 8'h22, 8'hFE);
        run_op("srl_80_by_2", 8'h02, 8'h80, 8'h28, 8'h20);
        run_op("add_opcode_upper_bits", 8'h05, 8'h03, 8'hE0, 8'h08);
        check("opcode_masked_e0", last_start_op, 6'h20);
        run_op("sra_80_by_1", 8'h01, 8'h80, 8'h27, 8'hC0);
        run_op("nor_00_00", 8'h00, 8'h00, 8'h29, 8'hFF);

        // Two commands queued at once: later bytes wait in the FIFO
        n0 = tx_log.size();
        @(posedge i_clk); #2;
        rx_q.push_back(8'h0C); rx_q.push_back(8'h0A); rx_q.push_back(8'h24);
        rx_q.push_back(8'h0C); rx_q.push_back(8'h0A); rx_q.push_back(8'h26);
        refresh();
        wait_writes(n0 + 2, 300);
        if (tx_log.size() >= n0 + 2) begin
            check("and_0c_0a", tx_log[n0], 8'h08);
            check("xor_0c_0a", tx_log[n0+1], 8'h06);
        end

        // Slow ALU
        lat_chk = 0; alu_delay = 4;
        run_op("or_slow_alu", 8'hF0, 8'h0F, 8'h25, 8'hFF);
        alu_delay = 0;

        // TX full for 50 cycles while a result waits
        n0 = tx_log.size();
        @(posedge i_clk); #2 i_tx_full = 1'b1;
        push(8'h0A); push(8'h05); push(8'h20);
        repeat (50) @(posedge i_clk);
        #2;
        check("stall_no_write", tx_log.size(), n0);
        check("stall_busy", o_busy, 1);
        i_tx_full = 1'b0;
        wait_writes(n0 + 1, 50);
        repeat (5) @(posedge i_clk);
        check("stall_single_write", tx_log.size(), n0 + 1);
        if (tx_log.size() > n0) check("stall_data", tx_log[n0], 8'h0F);
        lat_chk = 1;

        // Reset after the second byte
        push(8'h11); push(8'h22);
        k = 0;
        while (!(grp == 2 && rx_q.size() == 0) && k < 50) begin @(negedge i_clk); k++; end
        check("two_bytes_popped", grp, 2);
        repeat (3) @(posedge i_clk);
        #2 i_reset = 1'b0;
        #1 check_all_zero();
        repeat (3) @(posedge i_clk);
        #2 i_reset = 1'b1;
        n0 = tx_log.size();
        repeat (10) @(posedge i_clk);
        #2 check("no_write_after_reset", tx_log.size(), n0);
        run_op("add_after_reset", 8'h01, 8'h01, 8'h20, 8'h02);

`ifdef ALU_UART_IF_TIMEOUT_EN
        // Stall after the first byte long enough for the watchdog to fire
        chk_busy = 0; start_seen = 0;
        push(8'h07);
        repeat (20) @(posedge i_clk);
        #2;
        check("timeout_idle", o_busy, 0);
        check("timeout_no_start", start_seen, 0);
        check("timeout_operand_cleared", o_operando_a, 0);
        grp = 0; chk_busy = 1;
        run_op("add_after_timeout", 8'h04, 8'h04, 8'h20, 8'h08);
`endif

        repeat (5) @(posedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
